// File: rtl/modmul_pre_883.sv
// modmul_pre_883
//   Sequential 10x10 shift-add multiplier. It produces a 19-bit operand that is
//   congruent to a*b mod 883, which feeds the din_a input of the mod-883
//   Barrett reducer. One transaction at a time: IDLE -> MUL (10) -> FOLD -> DONE.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair presented      in_ready   accepting (IDLE only)
//   a, b       10-bit operands, sampled on the input handshake
//   out_valid  dout_a/err hold a result    out_ready  downstream accepts
//   dout_a     19-bit folded product (< 452096)
//   err        operand out-of-range flag, qualified by out_valid
//
// Configuration
//   RANGE_CHECK_EN  when defined, err = (a >= 883) | (b >= 883), registered on
//                   the input handshake and held through DONE. When undefined,
//                   err is tied low and no comparators are built.

module modmul_pre_883 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  a,
  input  logic [9:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [18:0] dout_a,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FOLD, S_DONE} state_t;

  // 883*1024 and 883*512
  localparam logic [19:0] FOLD_HI = 20'd904192;
  localparam logic [19:0] FOLD_LO = 20'd452096;

  state_t      state_q;
  logic [19:0] mcand_q;
  logic [9:0]  mplier_q;
  logic [19:0] acc_q;
  logic [3:0]  cnt_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [18:0] dout_q;

  logic [19:0] acc_d;
  logic [19:0] fold1;
  logic [18:0] fold_d;

  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  // Two conditional subtractions bring any 20-bit product below 883*512,
  // so the result fits in 19 bits and bit 19 can be dropped.
  always_comb begin
    fold1 = acc_q;
    if (acc_q >= FOLD_HI) begin
      fold1 = acc_q - FOLD_HI;
    end
    fold_d = fold1[18:0];
    if (fold1 >= FOLD_LO) begin
      fold_d = 19'(fold1 - FOLD_LO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mcand_q    <= {10'b0, a};
            mplier_q   <= b;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_MUL;
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[18:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[9:1]};
          cnt_q    <= cnt_q + 4'd1;
          if (cnt_q == 4'd9) begin
            state_q <= S_FOLD;
          end
        end
        S_FOLD: begin
          dout_q      <= fold_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout_a    = dout_q;

`ifdef RANGE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == S_IDLE && in_valid) begin
      err_q <= (a >= 10'd883) | (b >= 10'd883);
    end else if (state_q == S_DONE && out_ready) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_modmul_pre_883.sv
module tb_modmul_pre_883;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  a = '0;
  logic [9:0]  b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [18:0] dout_a;
  logic        err;

  modmul_pre_883 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout_a    (dout_a),
    .err       (err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [18:0] d;
    logic        e;
    int unsigned hs;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Stimulus phase: 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] va, input logic [9:0] vb,
                      input logic [18:0] exp_d, input logic rng, input bit hold);
    int unsigned w = 0;
    exp_t t;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    t.d = exp_d;
`ifdef RANGE_CHECK_EN
    t.e = rng;
`else
    t.e = 1'b0;
`endif
    t.hs = cyc + 1;
    sb.push_back(t);
    tick();
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned w = 0;
    while (sb.size() != 0 && w < 200) begin
      tick();
      w++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  // Monitor: latency on out_valid rise, payload on output handshake.
  initial begin
    logic prev_ov = 1'b0;
    exp_t t;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_ov) begin
        if (sb.size() != 0) check("latency", cyc - sb[0].hs, 11);
        else check("unexpected_valid", 1, 0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() != 0) begin
          t = sb.pop_front();
          check("dout_a", dout_a, t.d);
          check("err", err, t.e);
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_dout_a", dout_a, 0);
    check("rst_err", err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    out_ready = 1'b1;
    send(10'd882,  10'd882, 19'd325828, 1'b0, 1'b0); drain();
    send(10'd1023, 10'd1023, 19'd142337, 1'b1, 1'b0); drain();
    send(10'd0,    10'd500, 19'd0,      1'b0, 1'b0); drain();
    send(10'd1,    10'd1,   19'd1,      1'b0, 1'b0); drain();
    send(10'd600,  10'd700, 19'd420000, 1'b0, 1'b0); drain();
    send(10'd883,  10'd883, 19'd327593, 1'b1, 1'b0); drain();
    send(10'd882,  10'd1,   19'd882,    1'b0, 1'b0); drain();
    send(10'd1,    10'd883, 19'd883,    1'b1, 1'b0); drain();
    send(10'd700,  10'd700, 19'd37904,  1'b0, 1'b0); drain();

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    send(10'd37, 10'd512, 19'd18944, 1'b0, 1'b0);
    begin
      int unsigned w = 0;
      while (!out_valid && w < 50) begin
        tick();
        w++;
      end
    end
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_dout", dout_a, 18944);
      check("bp_in_ready", in_ready, 0);
      a = 10'(i * 37);
      b = 10'(i * 11);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_in_ready_after", in_ready, 1);
    check("bp_valid_after", out_valid, 0);
    check("bp_drained", sb.size(), 0);

    // Reset during the 5th MUL cycle aborts the transaction.
    send(10'd1000, 10'd1000, 19'd95808, 1'b1, 1'b0);
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_dout", dout_a, 0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    send(10'd2, 10'd3, 19'd6, 1'b0, 1'b0); drain();

    // Back-to-back with in_valid held high.
    out_ready = 1'b1;
    send(10'd1000, 10'd1000, 19'd95808, 1'b1, 1'b1);
    send(10'd37,   10'd512,  19'd18944, 1'b0, 1'b1);
    send(10'd882,  10'd882,  19'd325828, 1'b0, 1'b1);
    in_valid = 1'b0;
    drain();
    repeat (15) tick();
    check("idle_no_extra", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
